// File: rtl/mrjong_rom_loader_if.sv
// Byte-stream download port from data_io plus the demultiplexed ROM/PROM write side.
// master = download source / observer, slave = the loader.
interface mrjong_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        cpu_we;
  logic        gfx_we;
  logic        pal_we;
  logic        lut_we;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        rom_loaded;
  logic        load_error;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_we, gfx_we, pal_we, lut_we, wr_addr, wr_data, busy, rom_loaded, load_error
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_we, gfx_we, pal_we, lut_we, wr_addr, wr_data, busy, rom_loaded, load_error
  );
endinterface

// File: rtl/mrjong_rom_loader.sv
// MrJong ROM download demux: steers index-0 bytes to CPU/GFX/PAL/LUT write ports,
// counts bytes and validates the image size to qualify the core reset.
module mrjong_rom_loader #(
  parameter logic [15:0] CPU_SIZE = 16'h8000,
  parameter logic [15:0] GFX_SIZE = 16'h4000,
  parameter logic [15:0] PAL_SIZE = 16'h0020,
  parameter logic [15:0] LUT_SIZE = 16'h0100
) (
  input  logic clk_sys,
  input  logic reset,
  mrjong_rom_loader_if.slave io
);
  localparam logic [24:0] GFX_BASE  = 25'(CPU_SIZE);
  localparam logic [24:0] PAL_BASE  = GFX_BASE + 25'(GFX_SIZE);
  localparam logic [24:0] LUT_BASE  = PAL_BASE + 25'(PAL_SIZE);
  localparam logic [24:0] TOTAL     = LUT_BASE + 25'(LUT_SIZE);
  localparam logic [16:0] TOTAL_CNT = TOTAL[16:0];

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;

  state_t      state_q, state_d;
  logic        dl_q;
  logic [16:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  we_q, we_d;        // {lut, pal, gfx, cpu}
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        dl_rise, dl_fall, start;
  logic [3:0]  sel;
  logic [14:0] off;

  assign dl_rise = io.ioctl_download & ~dl_q;
  assign dl_fall = ~io.ioctl_download & dl_q;
  assign start   = dl_rise & (io.ioctl_index == 8'd0);

  // Region decode; offsets use 15-bit arithmetic since wr_addr is truncated anyway.
  always_comb begin
    sel = 4'b0000;
    off = io.ioctl_addr[14:0];
    if (io.ioctl_addr < GFX_BASE) begin
      sel = 4'b0001;
    end else if (io.ioctl_addr < PAL_BASE) begin
      sel = 4'b0010;
      off = io.ioctl_addr[14:0] - GFX_BASE[14:0];
    end else if (io.ioctl_addr < LUT_BASE) begin
      sel = 4'b0100;
      off = io.ioctl_addr[14:0] - PAL_BASE[14:0];
    end else if (io.ioctl_addr < TOTAL) begin
      sel = 4'b1000;
      off = io.ioctl_addr[14:0] - LUT_BASE[14:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    we_d      = 4'b0000;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // A write coinciding with the falling download edge still belongs to this image.
        if (io.ioctl_wr) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 17'd1;
          if (sel == 4'b0000) begin
            ovf_d = 1'b1;
          end else begin
            we_d      = sel;
            wr_addr_d = off;
            wr_data_d = io.ioctl_dout;
          end
        end
        if (dl_fall) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (cnt_q == TOTAL_CNT && !ovf_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dl_q      <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      we_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      dl_q      <= io.ioctl_download;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign io.cpu_we     = we_q[0];
  assign io.gfx_we     = we_q[1];
  assign io.pal_we     = we_q[2];
  assign io.lut_we     = we_q[3];
  assign io.wr_addr    = wr_addr_q;
  assign io.wr_data    = wr_data_q;
  assign io.busy       = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign io.rom_loaded = (state_q == S_DONE);
  assign io.load_error = (state_q == S_ERROR);
endmodule

// File: tb/tb_mrjong_rom_loader.sv
// Directed bench for mrjong_rom_loader: reset, abort, full/short/overflow images, index filter.
module tb_mrjong_rom_loader;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   tests   = 0;
  int   fails   = 0;

  mrjong_rom_loader_if bus ();

  mrjong_rom_loader dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .io      (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    reset = 1'b1;
    tick(); tick();
    tests++;
    if ({bus.cpu_we, bus.gfx_we, bus.pal_we, bus.lut_we, bus.wr_addr, bus.wr_data,
         bus.busy, bus.rom_loaded, bus.load_error} !== 30'd0) begin
      fails++;
      $display("FAIL reset_outputs: got cpu/gfx/pal/lut=%b%b%b%b addr=%h data=%h busy=%b ok=%b err=%b, want all 0",
               bus.cpu_we, bus.gfx_we, bus.pal_we, bus.lut_we, bus.wr_addr, bus.wr_data,
               bus.busy, bus.rom_loaded, bus.load_error);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_bytes();
    bus.ioctl_download = 1'b1;
    tick();
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++; $display("FAIL zero_busy_rise: busy=%b want 1", bus.busy);
    end
    bus.ioctl_download = 1'b0;
    tick();
    tests++;
    if ({bus.busy, bus.load_error} !== 2'b10) begin
      fails++; $display("FAIL zero_check: busy=%b err=%b want 1 0", bus.busy, bus.load_error);
    end
    tick();
    tests++;
    if ({bus.busy, bus.rom_loaded, bus.load_error} !== 3'b001) begin
      fails++; $display("FAIL zero_result: busy=%b ok=%b err=%b want 0 0 1",
                        bus.busy, bus.rom_loaded, bus.load_error);
    end
  endtask

  task automatic test_reset_mid_load();
    bus.ioctl_download = 1'b1;
    tick();
    tests++;
    if ({bus.busy, bus.load_error} !== 2'b10) begin
      fails++; $display("FAIL abort_entry: busy=%b err=%b want 1 0", bus.busy, bus.load_error);
    end
    for (int i = 0; i < 3; i++) begin
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(i);
      tick();
    end
    bus.ioctl_addr = 25'h5000; bus.ioctl_dout = 8'hA5;
    tick();
    tests++;
    if ({bus.cpu_we, bus.wr_addr, bus.wr_data} !== {1'b1, 15'h5000, 8'hA5}) begin
      fails++; $display("FAIL abort_pre_write: cpu_we=%b addr=%h data=%h want 1 5000 a5",
                        bus.cpu_we, bus.wr_addr, bus.wr_data);
    end
    #2;
    reset = 1'b1;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    tests++;
    if ({bus.cpu_we, bus.gfx_we, bus.pal_we, bus.lut_we, bus.wr_addr, bus.wr_data,
         bus.busy, bus.rom_loaded, bus.load_error} !== 30'd0) begin
      fails++;
      $display("FAIL abort_async: cpu_we=%b addr=%h data=%h busy=%b want all 0",
               bus.cpu_we, bus.wr_addr, bus.wr_data, bus.busy);
    end
    tick();
    reset = 1'b0;
    tick();
    tests++;
    if ({bus.busy, bus.rom_loaded, bus.load_error} !== 3'b000) begin
      fails++; $display("FAIL abort_idle: busy=%b ok=%b err=%b want 0 0 0",
                        bus.busy, bus.rom_loaded, bus.load_error);
    end
  endtask

  // Full image, one byte per cycle; the final byte is written while download falls.
  task automatic test_full_image();
    int n_cpu = 0, n_gfx = 0, n_pal = 0, n_lut = 0, n_multi = 0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < 'hC120; a++) begin
      bus.ioctl_wr       = 1'b1;
      bus.ioctl_addr     = 25'(a);
      bus.ioctl_dout     = a[7:0];
      bus.ioctl_download = (a != 'hC11F);
      tick();
      n_cpu += int'(bus.cpu_we); n_gfx += int'(bus.gfx_we);
      n_pal += int'(bus.pal_we); n_lut += int'(bus.lut_we);
      if (int'(bus.cpu_we) + int'(bus.gfx_we) + int'(bus.pal_we) + int'(bus.lut_we) > 1) n_multi++;
      if (a == 'h7FFF) begin
        tests++;
        if ({bus.cpu_we, bus.gfx_we, bus.wr_addr, bus.wr_data} !== {2'b10, 15'h7FFF, 8'hFF}) begin
          fails++; $display("FAIL edge_7fff: cpu=%b gfx=%b addr=%h data=%h want 1 0 7fff ff",
                            bus.cpu_we, bus.gfx_we, bus.wr_addr, bus.wr_data);
        end
      end
      if (a == 'h8000) begin
        tests++;
        if ({bus.cpu_we, bus.gfx_we, bus.wr_addr, bus.wr_data} !== {2'b01, 15'h0000, 8'h00}) begin
          fails++; $display("FAIL edge_8000: cpu=%b gfx=%b addr=%h data=%h want 0 1 0000 00",
                            bus.cpu_we, bus.gfx_we, bus.wr_addr, bus.wr_data);
        end
      end
      if (a == 'hC000) begin
        tests++;
        if ({bus.gfx_we, bus.pal_we, bus.wr_addr} !== {2'b01, 15'h0000}) begin
          fails++; $display("FAIL edge_c000: gfx=%b pal=%b addr=%h want 0 1 0000",
                            bus.gfx_we, bus.pal_we, bus.wr_addr);
        end
      end
      if (a == 'hC020) begin
        tests++;
        if ({bus.pal_we, bus.lut_we, bus.wr_addr, bus.wr_data} !== {2'b01, 15'h0000, 8'h20}) begin
          fails++; $display("FAIL edge_c020: pal=%b lut=%b addr=%h data=%h want 0 1 0000 20",
                            bus.pal_we, bus.lut_we, bus.wr_addr, bus.wr_data);
        end
      end
    end
    bus.ioctl_wr = 1'b0;
    tests++;
    if (n_cpu != 'h8000 || n_gfx != 'h4000) begin
      fails++; $display("FAIL count_cpu_gfx: cpu=%h gfx=%h want 8000 4000", n_cpu, n_gfx);
    end
    tests++;
    if (n_pal != 'h20 || n_lut != 'h100 || n_multi != 0) begin
      fails++; $display("FAIL count_pal_lut: pal=%h lut=%h multi=%0d want 20 100 0", n_pal, n_lut, n_multi);
    end
    tests++;
    if ({bus.busy, bus.rom_loaded, bus.load_error} !== 3'b100) begin
      fails++; $display("FAIL full_check: busy=%b ok=%b err=%b want 1 0 0",
                        bus.busy, bus.rom_loaded, bus.load_error);
    end
    tick();
    tests++;
    if ({bus.busy, bus.rom_loaded, bus.load_error} !== 3'b010) begin
      fails++; $display("FAIL full_done: busy=%b ok=%b err=%b want 0 1 0",
                        bus.busy, bus.rom_loaded, bus.load_error);
    end
    tests++;
    if ({bus.cpu_we, bus.gfx_we, bus.pal_we, bus.lut_we, bus.wr_addr, bus.wr_data} !== {4'b0000, 15'h00FF, 8'h1F}) begin
      fails++; $display("FAIL idle_hold: we=%b%b%b%b addr=%h data=%h want 0000 00ff 1f",
                        bus.cpu_we, bus.gfx_we, bus.pal_we, bus.lut_we, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_nonzero_index();
    int n_we = 0;
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(i + 1);
      tick();
      n_we += int'(bus.cpu_we) + int'(bus.gfx_we) + int'(bus.pal_we) + int'(bus.lut_we);
    end
    bus.ioctl_wr = 1'b0;
    tests++;
    if (n_we != 0) begin
      fails++; $display("FAIL idx1_strobes: got %0d strobes want 0", n_we);
    end
    bus.ioctl_download = 1'b0;
    tick(); tick();
    tests++;
    if ({bus.busy, bus.rom_loaded, bus.load_error} !== 3'b010) begin
      fails++; $display("FAIL idx1_state: busy=%b ok=%b err=%b want 0 1 0",
                        bus.busy, bus.rom_loaded, bus.load_error);
    end
    bus.ioctl_index = 8'd0;
  endtask

  task automatic test_short_image();
    bus.ioctl_download = 1'b1;
    tick();
    tests++;
    if ({bus.busy, bus.rom_loaded} !== 2'b10) begin
      fails++; $display("FAIL short_entry: busy=%b ok=%b want 1 0", bus.busy, bus.rom_loaded);
    end
    for (int a = 0; a < 'h100; a++) begin
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = a[7:0];
      tick();
    end
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    tick(); tick();
    tests++;
    if ({bus.busy, bus.rom_loaded, bus.load_error} !== 3'b001) begin
      fails++; $display("FAIL short_result: busy=%b ok=%b err=%b want 0 0 1",
                        bus.busy, bus.rom_loaded, bus.load_error);
    end
  endtask

  task automatic test_overflow();
    bus.ioctl_download = 1'b1;
    tick();
    tests++;
    if ({bus.busy, bus.load_error} !== 2'b10) begin
      fails++; $display("FAIL ovf_entry: busy=%b err=%b want 1 0", bus.busy, bus.load_error);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'hC11F; bus.ioctl_dout = 8'h3C;
    tick();
    tests++;
    if ({bus.lut_we, bus.wr_addr, bus.wr_data} !== {1'b1, 15'h00FF, 8'h3C}) begin
      fails++; $display("FAIL last_lut: lut=%b addr=%h data=%h want 1 00ff 3c",
                        bus.lut_we, bus.wr_addr, bus.wr_data);
    end
    bus.ioctl_addr = 25'hC120; bus.ioctl_dout = 8'h5A;
    tick();
    bus.ioctl_wr = 1'b0;
    tests++;
    if ({bus.cpu_we, bus.gfx_we, bus.pal_we, bus.lut_we} !== 4'b0000) begin
      fails++; $display("FAIL ovf_strobe: we=%b%b%b%b want 0000",
                        bus.cpu_we, bus.gfx_we, bus.pal_we, bus.lut_we);
    end
    bus.ioctl_download = 1'b0;
    tick(); tick();
    tests++;
    if ({bus.busy, bus.rom_loaded, bus.load_error} !== 3'b001) begin
      fails++; $display("FAIL ovf_result: busy=%b ok=%b err=%b want 0 0 1",
                        bus.busy, bus.rom_loaded, bus.load_error);
    end
  endtask

  initial begin
    test_reset();
    test_zero_bytes();
    test_reset_mid_load();
    test_full_image();
    test_nonzero_index();
    test_short_image();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mrjong_rom_loader.md
# mrjong_rom_loader

ROM download demultiplexer between `data_io` and `core` in the MrJong top level. Takes the serial byte stream (`ioctl_*`) for index 0 and steers each byte to the CPU ROM, graphics ROM, palette PROM or lookup PROM write port with a one-cycle registered write. Counts accepted bytes, validates the image size when the download ends, and produces the `rom_loaded` / `load_error` qualifiers that gate the core reset.

## Interface
- `CPU_SIZE`, 16'h8000: CPU ROM bytes, image base 0x0000
- `GFX_SIZE`, 16'h4000: graphics ROM bytes, follows CPU ROM
- `PAL_SIZE`, 16'h0020: palette PROM bytes, follows GFX
- `LUT_SIZE`, 16'h0100: lookup PROM bytes, follows PAL; TOTAL = sum = 0xC120
- `clk_sys`  in  1  system clock, 48 MHz
- `reset`  in  1  asynchronous, active-high reset
- `ioctl_download`  in  1  download active
- `ioctl_index`  in  8  download index; only 0 is handled
- `ioctl_wr`  in  1  single-cycle byte strobe
- `ioctl_addr`  in  25  image byte address
- `ioctl_dout`  in  8  image byte
- `cpu_we`, `gfx_we`, `pal_we`, `lut_we`  out  1 each  region write strobes, one-hot or all zero
- `wr_addr`  out  15  address relative to the selected region base
- `wr_data`  out  8  byte to write
- `busy`  out  1  high in LOAD and CHECK
- `rom_loaded`  out  1  valid image present
- `load_error`  out  1  last download had the wrong size or overflowed

## Operation
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- IDLE → LOAD on rising `ioctl_download` with `ioctl_index`==0. Entry clears the byte counter, the overflow flag, `rom_loaded` and `load_error`.
- A download with index ≠ 0 is ignored. State, flags and strobes are unchanged.
- In LOAD, each `ioctl_wr` is decoded against `ioctl_addr`:
  - addr < CPU_SIZE → cpu
  - addr < CPU_SIZE+GFX_SIZE → gfx
  - then pal, then lut
  - addr ≥ TOTAL → no strobe; set overflow.
- `wr_addr` = addr − region base, 15 bits, truncated. `wr_data` = `ioctl_dout`.
- The 17-bit byte counter increments on every `ioctl_wr` in LOAD, overflowing addresses included. It saturates at 0x1FFFF.
- Falling `ioctl_download` in LOAD → CHECK.
- CHECK takes one cycle. If counter==TOTAL and overflow is clear → DONE; otherwise → ERROR.
- DONE drives `rom_loaded`=1. ERROR drives `load_error`=1.
- From DONE or ERROR, a new index-0 rising download → LOAD.
- `ioctl_wr` in the same cycle that download falls is still accepted and counted.
- Download dropping after zero bytes → ERROR.

## Timing
- Reset values: state IDLE; all strobes 0; `wr_addr` 0; `wr_data` 0; `busy` 0; `rom_loaded` 0; `load_error` 0.
- Reset mid-LOAD aborts immediately to IDLE with all outputs at reset values.
- Write latency: `ioctl_wr` at cycle N → strobe, `wr_addr` and `wr_data` valid at N+1 for exactly one cycle.
- Back-to-back `ioctl_wr` on consecutive cycles must each yield a strobe. No stalls and no backpressure.
- Download edges are detected on a registered copy of `ioctl_download`.
- `busy` rises the cycle after the rising edge is detected.
- `rom_loaded` / `load_error` assert 2 cycles after the falling edge is sampled (CHECK, then DONE/ERROR).
- Outputs with `ioctl_wr` low in LOAD: strobes 0; `wr_addr` and `wr_data` hold their last values.

## Test plan
- Full image: index 0, addrs 0..0xC11F, one byte per cycle, data = addr[7:0]:
  - cpu_we ×0x8000, gfx_we ×0x4000, pal_we ×0x20, lut_we ×0x100
  - write at addr 0xC020 gives lut_we with wr_addr 0
  - `rom_loaded`=1 two cycles after download falls.
- Short image: addrs 0..0xC0FF → `load_error`=1, `rom_loaded`=0.
- Overflow: full image plus a write at 0xC120 → no strobe for that byte; `load_error`=1.
- Non-zero index: a DONE state, then an index-1 download with 16 writes → no strobes; `rom_loaded` stays 1.
- Reset at byte 0x5000 of a load → all outputs 0 at once. A subsequent full load gives `rom_loaded`=1.
- Boundary and edge write:
  - write at 0x7FFF → cpu_we, wr_addr 0x7FFF
  - write at 0x8000 → gfx_we, wr_addr 0
  - final `ioctl_wr` in the same cycle download falls is counted and the result is DONE.
